// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: EX operand bypass selection plus ID load-use hazard stall control
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   flush                      aborts any stall in progress
//   id_valid/id_src/id_src_used  ID instruction and its read operands
//   ex_src                     EX source register addresses
//   stg_valid/regwrite/memread/rd  per-stage producer info (0 = EX ... NSTG-1 = WB)
//   fwd_sel                    per EX source: 0 = register file, i = bypass from stage i
//   stall                      freeze PC/IF/ID, bubble into EX
//   fwd_err                    sticky flag: forward taken from a load that is not yet ready
//   perf_stall_cyc/perf_hazards  counters, built only with FWD_HAZARD_PERF_EN
module fwd_hazard_ctrl #(
   parameter int AW     = 5,
   parameter int NSRC   = 2,
   parameter int NSTG   = 4,
   parameter int LD_LAT = 3,
   parameter int SELW   = $clog2(NSTG)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic                 id_valid,
   input  logic [NSRC*AW-1:0]   id_src,
   input  logic [NSRC-1:0]      id_src_used,
   input  logic [NSRC*AW-1:0]   ex_src,
   input  logic [NSTG-1:0]      stg_valid,
   input  logic [NSTG-1:0]      stg_regwrite,
   input  logic [NSTG-1:0]      stg_memread,
   input  logic [NSTG*AW-1:0]   stg_rd,
   output logic [NSRC*SELW-1:0] fwd_sel,
   output logic                 stall,
   output logic                 fwd_err,
   output logic [31:0]          perf_stall_cyc,
   output logic [31:0]          perf_hazards
);
   localparam int CW = $clog2(LD_LAT + 1);
   typedef enum logic {IDLE, STALL} state_t;
   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d, need, need_s;
   logic            fwd_err_q, fwd_err_d;
   logic [NSRC-1:0] sel_ld;
   logic            ex_hit [NSRC][NSTG];
   logic            id_hit [NSRC][NSTG];
   for (genvar s = 0; s < NSRC; s++) begin : g_src
      for (genvar i = 0; i < NSTG; i++) begin : g_stg
         logic wr;
         assign wr = stg_valid[i] && stg_regwrite[i] && (stg_rd[i*AW +: AW] != '0);
         assign ex_hit[s][i] = wr && (stg_rd[i*AW +: AW] == ex_src[s*AW +: AW]);
         assign id_hit[s][i] = wr && (stg_rd[i*AW +: AW] == id_src[s*AW +: AW]);
      end
   end
   // Scan oldest to youngest so the youngest match is the one left standing.
   always_comb begin
      fwd_sel = '0;
      sel_ld  = '0;
      for (int s = 0; s < NSRC; s++)
         for (int i = NSTG - 1; i >= 1; i--)
            if (ex_hit[s][i]) begin
               fwd_sel[s*SELW +: SELW] = SELW'(i);
               sel_ld[s] = stg_memread[i] && (i < LD_LAT);
            end
      fwd_err_d = fwd_err_q | (|sel_ld);
   end
   // Bubbles owed: a load in stage j becomes forwardable after LD_LAT-(j+1) more cycles.
   always_comb begin
      need   = '0;
      need_s = '0;
      for (int s = 0; s < NSRC; s++) begin
         need_s = '0;
         if (id_valid && id_src_used[s])
            for (int j = NSTG - 1; j >= 0; j--)
               if (id_hit[s][j])
                  need_s = (stg_memread[j] && (LD_LAT > j + 1)) ? CW'(LD_LAT - j - 1) : '0;
         need = (need_s > need) ? need_s : need;
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         fwd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         fwd_err_q <= fwd_err_d;
      end
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else if (state_q == STALL) begin
         state_d = (cnt_q == CW'(1)) ? IDLE : STALL;
         cnt_d   = cnt_q - 1'b1;
      end else if (need != '0) begin
         state_d = (need > CW'(1)) ? STALL : IDLE;
         cnt_d   = need - 1'b1;
      end
   end
   always_comb begin
      stall   = rst_n && !flush && ((state_q == STALL) || (need != '0));
      fwd_err = fwd_err_q;
   end
`ifdef FWD_HAZARD_PERF_EN
   logic [31:0] perf_stall_cyc_q, perf_stall_cyc_d, perf_hazards_q, perf_hazards_d;
   always_comb begin
      perf_stall_cyc_d = perf_stall_cyc_q + (stall ? 32'd1 : 32'd0);
      perf_hazards_d   = perf_hazards_q + ((state_q == IDLE && need != '0 && !flush) ? 32'd1 : 32'd0);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         perf_stall_cyc_q <= '0;
         perf_hazards_q   <= '0;
      end else begin
         perf_stall_cyc_q <= perf_stall_cyc_d;
         perf_hazards_q   <= perf_hazards_d;
      end
   assign perf_stall_cyc = perf_stall_cyc_q;
   assign perf_hazards   = perf_hazards_q;
`else
   assign perf_stall_cyc = '0;
   assign perf_hazards   = '0;
`endif
endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb_fwd_hazard_ctrl: directed checks of bypass selects, load-use stalls, flush, reset and fwd_err
module tb_fwd_hazard_ctrl;
   localparam int AW = 5, NSRC = 2, NSTG = 4, LD_LAT = 3, SELW = 2;
   logic                 clk = 1'b0, rst_n = 1'b0, flush = 1'b0, id_valid = 1'b0;
   logic [NSRC*AW-1:0]   id_src = '0, ex_src = '0;
   logic [NSRC-1:0]      id_src_used = '0;
   logic [NSTG-1:0]      stg_valid = '0, stg_regwrite = '0, stg_memread = '0;
   logic [NSTG*AW-1:0]   stg_rd = '0;
   logic [NSRC*SELW-1:0] fwd_sel;
   logic                 stall, fwd_err;
   logic [31:0]          perf_stall_cyc, perf_hazards;
   int compared = 0, mismatched = 0;
   fwd_hazard_ctrl #(.AW(AW), .NSRC(NSRC), .NSTG(NSTG), .LD_LAT(LD_LAT)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid), .id_src(id_src),
      .id_src_used(id_src_used), .ex_src(ex_src), .stg_valid(stg_valid),
      .stg_regwrite(stg_regwrite), .stg_memread(stg_memread), .stg_rd(stg_rd),
      .fwd_sel(fwd_sel), .stall(stall), .fwd_err(fwd_err),
      .perf_stall_cyc(perf_stall_cyc), .perf_hazards(perf_hazards));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic clr_stg();
      stg_valid = '0; stg_regwrite = '0; stg_memread = '0; stg_rd = '0;
   endtask
   task automatic clr();
      clr_stg(); id_valid = 1'b0; id_src = '0; id_src_used = '0; ex_src = '0; flush = 1'b0;
   endtask
   task automatic stage(input int i, input logic [AW-1:0] rd, input logic ld);
      stg_valid[i] = 1'b1; stg_regwrite[i] = 1'b1; stg_memread[i] = ld; stg_rd[i*AW +: AW] = rd;
   endtask
   task automatic ld7(input int i);
      clr_stg(); stage(i, 5'd7, 1'b1);
   endtask
   task automatic nxt();
      @(posedge clk); #1;
   endtask
   function automatic logic [31:0] sel(input int s);
      return 32'(fwd_sel[s*SELW +: SELW]);
   endfunction
   initial begin
      #2;
      chk("rst_stall", 32'(stall), 0);
      chk("rst_err", 32'(fwd_err), 0);
      chk("rst_perf_cyc", perf_stall_cyc, 0);
      #10 rst_n = 1'b1;
      nxt();
      stage(1, 5'd5, 1'b0); ex_src[0 +: AW] = 5'd5; #1;
      chk("alu_sel0", sel(0), 1);
      chk("alu_sel1", sel(1), 0);
      chk("alu_stall", 32'(stall), 0);
      clr(); stage(1, 5'd5, 1'b0); stage(3, 5'd5, 1'b0); ex_src = {5'd5, 5'd5}; #1;
      chk("young_sel0", sel(0), 1);
      chk("young_sel1", sel(1), 1);
      clr(); stage(1, 5'd0, 1'b0); stage(3, 5'd0, 1'b0); #1;
      chk("r0_sel0", sel(0), 0);
      chk("r0_sel1", sel(1), 0);
      clr(); stage(3, 5'd6, 1'b0); stage(2, 5'd4, 1'b0); ex_src[AW +: AW] = 5'd6; #1;
      chk("wb_sel1", sel(1), 3);
      clr(); id_valid = 1'b1; id_src[AW +: AW] = 5'd7; id_src_used = 2'b10; ld7(0); #1;
      chk("ld0_c0", 32'(stall), 1);
      nxt(); ld7(1); #1;
      chk("ld0_c1", 32'(stall), 1);
      nxt(); ld7(2); #1;
      chk("ld0_c2", 32'(stall), 0);
`ifdef FWD_HAZARD_PERF_EN
      chk("perf_cyc", perf_stall_cyc, 2);
      chk("perf_haz", perf_hazards, 1);
`else
      chk("perf_cyc_off", perf_stall_cyc, 0);
      chk("perf_haz_off", perf_hazards, 0);
`endif
      nxt(); ld7(1); #1;
      chk("ld1_c0", 32'(stall), 1);
      nxt(); ld7(2); #1;
      chk("ld1_c1", 32'(stall), 0);
      nxt(); ld7(2); #1;
      chk("ld2", 32'(stall), 0);
      ld7(0); id_src_used = 2'b00; #1;
      chk("unused", 32'(stall), 0);
      id_src_used = 2'b10; id_valid = 1'b0; #1;
      chk("id_invalid", 32'(stall), 0);
      id_valid = 1'b1; #1;
      chk("fl_c0", 32'(stall), 1);
      nxt(); flush = 1'b1; #1;
      chk("fl_c1", 32'(stall), 0);
      nxt(); flush = 1'b0; ld7(2); #1;
      chk("fl_idle", 32'(stall), 0);
      ld7(0); flush = 1'b1; #1;
      chk("fl_prio", 32'(stall), 0);
      nxt(); flush = 1'b0; ld7(2); #1;
      chk("fl_prio_idle", 32'(stall), 0);
      ld7(0); #1;
      chk("rs_c0", 32'(stall), 1);
      nxt(); rst_n = 1'b0; #1;
      chk("rs_stall", 32'(stall), 0);
      chk("rs_perf_cyc", perf_stall_cyc, 0);
      chk("rs_perf_haz", perf_hazards, 0);
      rst_n = 1'b1; ld7(2); #1;
      chk("rs_idle", 32'(stall), 0);
      nxt(); clr(); stage(1, 5'd9, 1'b1); ex_src[0 +: AW] = 5'd9; #1;
      chk("err_sel0", sel(0), 1);
      chk("err_pre", 32'(fwd_err), 0);
      nxt();
      chk("err_set", 32'(fwd_err), 1);
      clr(); nxt(); nxt();
      chk("err_hold", 32'(fwd_err), 1);
      rst_n = 1'b0; #1;
      chk("err_rst", 32'(fwd_err), 0);
      rst_n = 1'b1;
      nxt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
